calc_issuer: RTL and testbench

Command-side front end for the `calculator` block. It buffers operation requests from a valid/ready command port and drives operands and op code onto the calculator's inputs one request at a time. It captures the registered result at the correct clock edge and returns it on a valid/ready response port with the request's tag. It is the initiator paired with the calculator responder.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_issuer_if.sv | 44 ++++
 rtl/calc_issuer_fifo.sv | 62 ++++++
 rtl/calc_issuer.sv | 197 +++++++++++++++++++
 tb/tb_calc_issuer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator command path.
package calc_pkg;

    localparam int CALC_DATA_W = 16;
    localparam logic [CALC_DATA_W-1:0] CALC_DIV0_RESULT = 16'hFFFF;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        DIV = 2'b11
    } calc_op_e;

    // Packed so that a occupies the MSBs of the 34-bit command word.
    typedef struct packed {
        logic [CALC_DATA_W-1:0] a;
        logic [CALC_DATA_W-1:0] b;
        calc_op_e               op;
    } calc_cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } issuer_state_e;

    localparam int CALC_CMD_W = $bits(calc_cmd_t);

endpackage

// File: rtl/calc_issuer_if.sv
// Bundle of the command, calculator and response ports of calc_issuer.
// master is the issuer's own view; slave is the view of its surroundings.
interface calc_issuer_if #(
    parameter int TAG_W = 4
);
    import calc_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [CALC_DATA_W-1:0] cmd_a;
    logic [CALC_DATA_W-1:0] cmd_b;
    logic [1:0]             cmd_op;
    logic [TAG_W-1:0]       cmd_tag;

    logic [CALC_DATA_W-1:0] calc_a;
    logic [CALC_DATA_W-1:0] calc_b;
    logic [1:0]             calc_op;
    logic [CALC_DATA_W-1:0] calc_result;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [CALC_DATA_W-1:0] rsp_result;
    logic [TAG_W-1:0]       rsp_tag;
    logic                   rsp_err;

    modport master (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output calc_a, calc_b, calc_op,
        input  calc_result,
        output rsp_valid, rsp_result, rsp_tag, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  calc_a, calc_b, calc_op,
        output calc_result,
        input  rsp_valid, rsp_result, rsp_tag, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/calc_issuer_fifo.sv
// calc_cmd_fifo: first-word-fall-through command FIFO with synchronous
// active-low reset; the head entry is readable whenever the FIFO is non-empty.
module calc_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 38
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_reg[rd_ptr_reg];

    // Storage carries no reset: stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/calc_issuer.sv
// calc_issuer: buffers calculator requests and issues them one at a time.
// Optional CALC_ISSUER_DIV0_CHECK_EN answers divide-by-zero locally with rsp_err.
module calc_issuer
    import calc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    calc_issuer_if.master bus
);
    localparam int FIFO_W = CALC_CMD_W + TAG_W;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    issuer_state_e          state_reg;
    issuer_state_e          state_next;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [FIFO_W-1:0]      fifo_wdata;
    logic [FIFO_W-1:0]      fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    calc_cmd_t              head_cmd;
    logic [TAG_W-1:0]       head_tag;
    logic                   head_div0;
    logic                   rsp_fire;

    logic                   load_calc;
    logic                   load_div0;
    logic                   capture;
    logic                   clear_rsp;

    logic [CALC_DATA_W-1:0] calc_a_reg;
    logic [CALC_DATA_W-1:0] calc_b_reg;
    calc_op_e               calc_op_reg;
    logic [TAG_W-1:0]       tag_reg;
    logic                   rsp_valid_reg;
    logic [CALC_DATA_W-1:0] rsp_result_reg;
    logic [TAG_W-1:0]       rsp_tag_reg;

    assign fifo_push  = bus.cmd_valid && bus.cmd_ready;
    assign fifo_wdata = {bus.cmd_tag, bus.cmd_a, bus.cmd_b, bus.cmd_op};
    assign head_cmd   = fifo_rdata[CALC_CMD_W-1:0];
    assign head_tag   = fifo_rdata[FIFO_W-1 -: TAG_W];
    assign rsp_fire   = rsp_valid_reg && bus.rsp_ready;

    calc_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef CALC_ISSUER_DIV0_CHECK_EN
    assign head_div0 = (head_cmd.op == DIV) && (head_cmd.b == '0);
`else
    assign head_div0 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Leaving IDLE and completing a handshake in RESP share the same dispatch.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = head_div0 ? RESP : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT:  state_next = RESP;
            RESP: begin
                if (rsp_fire) begin
                    if (!fifo_empty) begin
                        state_next = head_div0 ? RESP : ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop  = 1'b0;
        load_calc = 1'b0;
        load_div0 = 1'b0;
        capture   = 1'b0;
        clear_rsp = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    load_calc = !head_div0;
                    load_div0 = head_div0;
                end
            end
            WAIT: capture = 1'b1;
            RESP: begin
                if (rsp_fire) begin
                    clear_rsp = 1'b1;
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        load_calc = !head_div0;
                        load_div0 = head_div0;
                    end
                end
            end
            default: ;
        endcase
    end

    // The tag is parked in tag_reg so rsp_tag only moves when RESP is entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            calc_a_reg  <= '0;
            calc_b_reg  <= '0;
            calc_op_reg <= ADD;
            tag_reg     <= '0;
        end else if (load_calc) begin
            calc_a_reg  <= head_cmd.a;
            calc_b_reg  <= head_cmd.b;
            calc_op_reg <= head_cmd.op;
            tag_reg     <= head_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_tag_reg    <= '0;
        end else if (capture) begin
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= bus.calc_result;
            rsp_tag_reg    <= tag_reg;
        end else if (load_div0) begin
            rsp_valid_reg  <= 1'b1;
            rsp_result_reg <= CALC_DIV0_RESULT;
            rsp_tag_reg    <= head_tag;
        end else if (clear_rsp) begin
            rsp_valid_reg  <= 1'b0;
        end
    end

`ifdef CALC_ISSUER_DIV0_CHECK_EN
    logic rsp_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_err_reg <= 1'b0;
        end else if (capture) begin
            rsp_err_reg <= 1'b0;
        end else if (load_div0) begin
            rsp_err_reg <= 1'b1;
        end
    end

    assign bus.rsp_err = rsp_err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.cmd_ready  = !fifo_full;
    assign bus.calc_a     = calc_a_reg;
    assign bus.calc_b     = calc_b_reg;
    assign bus.calc_op    = calc_op_reg;
    assign bus.rsp_valid  = rsp_valid_reg;
    assign bus.rsp_result = rsp_result_reg;
    assign bus.rsp_tag    = rsp_tag_reg;

`ifndef SYNTHESIS
    a_fifo_flags: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_empty == (fifo_count == '0));
`endif

endmodule

// File: tb/tb_calc_issuer.sv
// Directed bench for calc_issuer with a registered calculator stub; build with
// or without CALC_ISSUER_DIV0_CHECK_EN.
module tb_calc_issuer;
    import calc_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   last_wait = 0;

    calc_issuer_if #(.TAG_W(4)) bus ();

    calc_issuer #(
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] calc_model(logic [15:0] a, logic [15:0] b, logic [1:0] op);
        logic [31:0] p;
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   begin p = a * b; return p[15:0]; end
            default: return (b == 16'd0) ? 16'hFFFF : a / b;
        endcase
    endfunction

    // Calculator stand-in: result registered one edge after operands are sampled.
    always @(posedge clk) bus.calc_result <= calc_model(bus.calc_a, bus.calc_b, bus.calc_op);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op,
                        input logic [3:0] tag);
        int n = 0;
        bus.cmd_a = a; bus.cmd_b = b; bus.cmd_op = op; bus.cmd_tag = tag;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin tick(); n++; end
        if (!bus.cmd_ready) chk("push_timeout", 32'd0, 32'd1);
        else tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string nm, input logic [15:0] exp_res, input logic [3:0] exp_tag,
                            input logic exp_err);
        int n = 0;
        while (!bus.rsp_valid && n < 50) begin tick(); n++; end
        last_wait = n;
        if (!bus.rsp_valid) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else begin
            $display("rsp %s: tag=%0d result=%04h err=%0d wait=%0d", nm, bus.rsp_tag,
                     bus.rsp_result, bus.rsp_err, n);
            chk({nm, "_result"}, 32'(bus.rsp_result), 32'(exp_res));
            chk({nm, "_tag"}, 32'(bus.rsp_tag), 32'(exp_tag));
            chk({nm, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;
        bus.rsp_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_calc_a", 32'(bus.calc_a), 32'd0);
        chk("rst_calc_b", 32'(bus.calc_b), 32'd0);
        chk("rst_calc_op", 32'(bus.calc_op), 32'd0);
        chk("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single add, response three edges after accept.
        push(16'd3, 16'd5, 2'b00, 4'd2);
        wait_rsp("add", 16'd8, 4'd2, 1'b0);
        chk("add_latency", 32'(last_wait), 32'd3);
        chk("add_calc_a", 32'(bus.calc_a), 32'd3);
        chk("add_calc_b", 32'(bus.calc_b), 32'd5);
        chk("add_valid_clr", 32'(bus.rsp_valid), 32'd0);
        tick();

        // Fill with the consumer stalled: first entry pops, then 4 more fill the FIFO.
        push(16'd7,   16'd6,   2'b10, 4'd1);
        push(16'd100, 16'd1,   2'b01, 4'd3);
        push(16'd0,   16'd1,   2'b01, 4'd4);
        push(16'd300, 16'd300, 2'b10, 4'd5);
        push(16'd100, 16'd7,   2'b11, 4'd6);
        chk("fill_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_result", 32'(bus.rsp_result), 32'd42);
            chk("stall_tag", 32'(bus.rsp_tag), 32'd1);
            chk("stall_calc_a", 32'(bus.calc_a), 32'd7);
            chk("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            tick();
        end
        wait_rsp("mul", 16'd42, 4'd1, 1'b0);
        chk("hs_calc_a", 32'(bus.calc_a), 32'd100);
        chk("hs_calc_b", 32'(bus.calc_b), 32'd1);
        chk("hs_calc_op", 32'(bus.calc_op), 32'd1);
        chk("hs_valid_clr", 32'(bus.rsp_valid), 32'd0);
        chk("hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        wait_rsp("sub", 16'd99, 4'd3, 1'b0);
        chk("b2b_latency", 32'(last_wait), 32'd2);
        wait_rsp("sub_wrap", 16'hFFFF, 4'd4, 1'b0);
        wait_rsp("mul_wrap", 16'h5F90, 4'd5, 1'b0);
        wait_rsp("div", 16'd14, 4'd6, 1'b0);
        tick();

        // Divide by zero after 100/7 left calc_b at 7.
        push(16'd9, 16'd0, 2'b11, 4'd7);
`ifdef CALC_ISSUER_DIV0_CHECK_EN
        wait_rsp("div0", 16'hFFFF, 4'd7, 1'b1);
        chk("div0_latency", 32'(last_wait), 32'd1);
        chk("div0_calc_a", 32'(bus.calc_a), 32'd100);
        chk("div0_calc_b", 32'(bus.calc_b), 32'd7);
`else
        wait_rsp("div0", 16'hFFFF, 4'd7, 1'b0);
        chk("div0_latency", 32'(last_wait), 32'd3);
        chk("div0_calc_a", 32'(bus.calc_a), 32'd9);
        chk("div0_calc_b", 32'(bus.calc_b), 32'd0);
`endif
        tick();

        // Reset while the first command is in WAIT with two more queued.
        push(16'd1, 16'd1, 2'b00, 4'd8);
        push(16'd2, 16'd2, 2'b00, 4'd9);
        push(16'd3, 16'd3, 2'b00, 4'd10);
        chk("mid_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_calc_a", 32'(bus.calc_a), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mid_rst_calc_a", 32'(bus.calc_a), 32'd0);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        saw = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.rsp_valid) saw++;
        end
        bus.rsp_ready = 1'b0;
        chk("post_rst_no_rsp", 32'(saw), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
